// File: rtl/muldiv_pkg.sv
// Shared types and constants for the multiply/divide sequencer.
package muldiv_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2
    } state_t;

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

    // Wait counter must be able to hold the value TIMEOUT itself.
    function automatic int cnt_width(input int timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/muldiv_ctrl_hilo_regs.sv
// Architectural HI/LO pair; a unit commit takes priority over MTHI/MTLO writes.
module hilo_regs (
    input  logic        clk,
    input  logic        reset,
    input  logic        commit,
    input  logic [31:0] commit_hi,
    input  logic [31:0] commit_lo,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    always_ff @(posedge clk) begin
        if (!reset) begin
            hi <= '0;
            lo <= '0;
        end else if (commit) begin
            hi <= commit_hi;
            lo <= commit_lo;
        end else begin
            if (hi_we) hi <= wdata;
            if (lo_we) lo <= wdata;
        end
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// Sequencer that launches the shared MULT/DIV units, waits for done and
// commits the result into HI/LO, with div-by-zero and timeout reporting.
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int TIMEOUT = 48
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_start,
    input  logic        op_sel,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        op_done,
    output logic        div_zero,
    output logic        timeout,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        mult_start,
    output logic        div_start,
    output logic [31:0] mult_a,
    output logic [31:0] mult_b,
    output logic [31:0] div_a,
    output logic [31:0] div_b,
    input  logic        mult_done,
    input  logic        div_done,
    input  logic [31:0] mult_hi,
    input  logic [31:0] mult_lo,
    input  logic [31:0] div_quot,
    input  logic [31:0] div_rem
);

    localparam int CNT_W = cnt_width(TIMEOUT);

    state_t             state, state_nx;
    logic               op_q, op_nx;
    logic [31:0]        a_q, a_nx, b_q, b_nx;
    logic [CNT_W-1:0]   cnt, cnt_nx;
    logic               op_done_nx, div_zero_nx, timeout_nx;
    logic               mult_start_nx, div_start_nx;
    logic               unit_done, commit;
    logic [31:0]        commit_hi, commit_lo;

    assign unit_done = (op_q == OP_DIV) ? div_done : mult_done;
    assign commit_hi = (op_q == OP_DIV) ? div_rem  : mult_hi;
    assign commit_lo = (op_q == OP_DIV) ? div_quot : mult_lo;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            op_q       <= OP_MULT;
            a_q        <= '0;
            b_q        <= '0;
            cnt        <= '0;
            op_done    <= 1'b0;
            div_zero   <= 1'b0;
            timeout    <= 1'b0;
            mult_start <= 1'b0;
            div_start  <= 1'b0;
        end else begin
            state      <= state_nx;
            op_q       <= op_nx;
            a_q        <= a_nx;
            b_q        <= b_nx;
            cnt        <= cnt_nx;
            op_done    <= op_done_nx;
            div_zero   <= div_zero_nx;
            timeout    <= timeout_nx;
            mult_start <= mult_start_nx;
            div_start  <= div_start_nx;
        end
    end

    always_comb begin
        state_nx      = state;
        op_nx         = op_q;
        a_nx          = a_q;
        b_nx          = b_q;
        cnt_nx        = cnt;
        op_done_nx    = 1'b0;
        div_zero_nx   = 1'b0;
        timeout_nx    = 1'b0;
        mult_start_nx = 1'b0;
        div_start_nx  = 1'b0;
        commit        = 1'b0;
        case (state)
            IDLE: begin
                if (op_start) begin
                    if (op_sel == OP_DIV && b == 32'd0) begin
                        op_done_nx  = 1'b1;
                        div_zero_nx = 1'b1;
                    end else begin
                        a_nx          = a;
                        b_nx          = b;
                        op_nx         = op_sel;
                        mult_start_nx = (op_sel == OP_MULT);
                        div_start_nx  = (op_sel == OP_DIV);
                        state_nx      = LAUNCH;
                    end
                end
            end
            LAUNCH: begin
                cnt_nx   = '0;
                state_nx = WAIT;
            end
            WAIT: begin
                // Done is only trusted here, after the unit has seen start.
                if (unit_done) begin
                    commit     = 1'b1;
                    op_done_nx = 1'b1;
                    state_nx   = IDLE;
                end else if (cnt == CNT_W'(TIMEOUT)) begin
                    op_done_nx = 1'b1;
                    timeout_nx = 1'b1;
                    state_nx   = IDLE;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign busy   = (state != IDLE);
    assign mult_a = a_q;
    assign mult_b = b_q;
    assign div_a  = a_q;
    assign div_b  = b_q;

    hilo_regs u_hilo (
        .clk       (clk),
        .reset     (reset),
        .commit    (commit),
        .commit_hi (commit_hi),
        .commit_lo (commit_lo),
        .hi_we     (hi_we && state == IDLE),
        .lo_we     (lo_we && state == IDLE),
        .wdata     (wdata),
        .hi        (hi),
        .lo        (lo)
    );

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl with simple multiplier/divider unit models.
module tb_muldiv_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        op_start = 1'b0;
    logic        op_sel = 1'b0;
    logic [31:0] a = '0, b = '0;
    logic        hi_we = 1'b0, lo_we = 1'b0;
    logic [31:0] wdata = '0;
    logic        busy, op_done, div_zero, timeout;
    logic [31:0] hi, lo;
    logic        mult_start, div_start;
    logic [31:0] mult_a, mult_b, div_a, div_b;
    logic        mult_done = 1'b0, div_done = 1'b0;
    logic [31:0] mult_hi = '0, mult_lo = '0, div_quot = '0, div_rem = '0;

    muldiv_ctrl #(.TIMEOUT(48)) dut (
        .clk(clk), .reset(reset), .op_start(op_start), .op_sel(op_sel),
        .a(a), .b(b), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .busy(busy), .op_done(op_done), .div_zero(div_zero), .timeout(timeout),
        .hi(hi), .lo(lo), .mult_start(mult_start), .div_start(div_start),
        .mult_a(mult_a), .mult_b(mult_b), .div_a(div_a), .div_b(div_b),
        .mult_done(mult_done), .div_done(div_done),
        .mult_hi(mult_hi), .mult_lo(mult_lo),
        .div_quot(div_quot), .div_rem(div_rem)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Multiplier model: done rises 32 cycles after it samples start, then holds.
    logic [5:0]  mcnt = '0;
    logic [63:0] prod;
    always_comb prod = {{32{mult_a[31]}}, mult_a} * {{32{mult_b[31]}}, mult_b};
    always @(posedge clk) begin
        if (mult_start) begin
            mcnt      <= 6'd32;
            mult_done <= 1'b0;
            {mult_hi, mult_lo} <= prod;
        end else if (mcnt != 6'd0) begin
            mcnt <= mcnt - 6'd1;
            if (mcnt == 6'd1) mult_done <= 1'b1;
        end
    end

    // Divider model: done after 10 cycles, or never when div_hang is set.
    logic       div_hang = 1'b0;
    logic [5:0] dcnt = '0;
    always @(posedge clk) begin
        if (div_start) begin
            dcnt     <= div_hang ? 6'd0 : 6'd10;
            div_done <= 1'b0;
            if (div_b != 32'd0) begin
                div_quot <= $signed(div_a) / $signed(div_b);
                div_rem  <= $signed(div_a) % $signed(div_b);
            end
        end else if (dcnt != 6'd0) begin
            dcnt <= dcnt - 6'd1;
            if (dcnt == 6'd1) div_done <= 1'b1;
        end
    end

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        logic        to;
        int          cyc;
        int          mst;
        int          dst;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    int   mst = 0, dst = 0;
    int   exp_mst = 0, exp_dst = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, want);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (mult_start) mst++;
        if (div_start)  dst++;
        if (op_done) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_op_done: got op_done at cycle %0d want none", cyc);
            end else begin
                e = q.pop_front();
                chk("hi",          64'(hi),       64'(e.hi));
                chk("lo",          64'(lo),       64'(e.lo));
                chk("div_zero",    64'(div_zero), 64'(e.dz));
                chk("timeout",     64'(timeout),  64'(e.to));
                chk("done_cycle",  64'(cyc),      64'(e.cyc));
                chk("busy_at_done", 64'(busy),    64'(0));
                chk("mult_starts", 64'(mst),      64'(e.mst));
                chk("div_starts",  64'(dst),      64'(e.dst));
            end
        end
    end

    // Issue one command at a negedge; returns at the negedge after the accept edge.
    task automatic do_op(input logic sel, input logic [31:0] ia, input logic [31:0] ib,
                         input logic [31:0] ehi, input logic [31:0] elo,
                         input logic edz, input logic eto, input int lat, input bit push);
        exp_t e;
        op_start = 1'b1;
        op_sel   = sel;
        a        = ia;
        b        = ib;
        if (sel == 1'b0) exp_mst++;
        else if (ib != 32'd0) exp_dst++;
        if (push) begin
            e.hi = ehi; e.lo = elo; e.dz = edz; e.to = eto;
            e.cyc = cyc + 1 + lat; e.mst = exp_mst; e.dst = exp_dst;
            q.push_back(e);
        end
        @(posedge clk);
        #1;
        op_start = 1'b0;
        hi_we    = 1'b0;
        lo_we    = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_done(input int bound);
        bit ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            if (q.size() == 0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL wait_done: got %0d pending after %0d cycles want 0", q.size(), bound);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_hi",   64'(hi), 64'(0));
        chk("rst_lo",   64'(lo), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(op_done), 64'(0));
        reset = 1'b1;
        @(negedge clk);

        // DIV 100/7
        do_op(1'b1, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 1'b0, 12, 1'b1);
        chk("div_launch_busy", 64'(busy), 64'(1));
        chk("div_launch_start", 64'(div_start), 64'(1));
        chk("div_a_latched", 64'(div_a), 64'(100));
        wait_done(40);

        // MULT 7 * -3 with div_done still high from the divide
        do_op(1'b0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 1'b0, 34, 1'b1);
        chk("mult_launch_start", 64'(mult_start), 64'(1));
        chk("mult_b_latched", 64'(mult_b), 64'hFFFF_FFFD);
        wait_done(60);

        // MTHI / MTLO
        hi_we = 1'b1; wdata = 32'h11;
        @(posedge clk); #1;
        hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h22;
        @(posedge clk); #1;
        lo_we = 1'b0;
        @(negedge clk);
        chk("mthi", 64'(hi), 64'h11);
        chk("mtlo", 64'(lo), 64'h22);

        // DIV 5/0: immediate div_zero, no launch
        do_op(1'b1, 32'd5, 32'd0, 32'h11, 32'h22, 1'b1, 1'b0, 0, 1'b1);
        chk("dz_busy", 64'(busy), 64'(0));
        wait_done(5);
        @(negedge clk);
        chk("dz_busy_after", 64'(busy), 64'(0));

        // Divider that never answers, while mult_done is stale high
        div_hang = 1'b1;
        do_op(1'b1, 32'd9, 32'd3, 32'h11, 32'h22, 1'b0, 1'b1, 50, 1'b1);
        wait_done(80);
        div_hang = 1'b0;

        // MULT 2*3
        do_op(1'b0, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0, 1'b0, 34, 1'b1);
        wait_done(60);

        // MULT -5*6 with stale done; op_start and MTHI while busy are ignored
        do_op(1'b0, 32'hFFFF_FFFB, 32'd6, 32'hFFFF_FFFF, 32'hFFFF_FFE2, 1'b0, 1'b0, 34, 1'b1);
        repeat (4) @(negedge clk);
        op_start = 1'b1; op_sel = 1'b1; a = 32'd1; b = 32'd1;
        hi_we = 1'b1; wdata = 32'hDEAD;
        @(posedge clk); #1;
        op_start = 1'b0; hi_we = 1'b0;
        @(negedge clk);
        chk("busy_ignore_hi", 64'(hi), 64'(0));
        chk("busy_ignore_busy", 64'(busy), 64'(1));
        wait_done(60);

        // Reset in the middle of WAIT
        do_op(1'b0, 32'd3, 32'd3, 32'd0, 32'd0, 1'b0, 1'b0, 0, 1'b0);
        repeat (9) @(negedge clk);
        chk("pre_rst_busy", 64'(busy), 64'(1));
        reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_busy",   64'(busy), 64'(0));
        chk("mid_rst_hi",     64'(hi), 64'(0));
        chk("mid_rst_lo",     64'(lo), 64'(6'd0));
        chk("mid_rst_mult_a", 64'(mult_a), 64'(0));
        chk("mid_rst_start",  64'(mult_start), 64'(0));
        reset = 1'b1;
        repeat (40) @(negedge clk);
        chk("post_rst_lo", 64'(lo), 64'(0));

        // MULT 4*4 with MTHI in the accept cycle, then the commit overwrites
        hi_we = 1'b1; wdata = 32'hABC;
        do_op(1'b0, 32'd4, 32'd4, 32'd0, 32'd16, 1'b0, 1'b0, 34, 1'b1);
        chk("mthi_same_cycle", 64'(hi), 64'hABC);
        wait_done(60);

        repeat (3) @(negedge clk);
        chk("queue_empty", 64'(q.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
